// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid register.
package pipe_pkg;

  // Occupancy of the skid register: no entry, main entry only, main plus skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Width of the optional performance counters.
  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for stall/bubble statistics.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count qualifying cycles; hold at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages. All outputs are driven
// from registers, so in_ready never depends combinationally on out_ready.
// Optional feature: define PIPE_SKID_PERF_EN to add stall_cnt/bubble_cnt.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit CLR_ON_FLUSH = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, consume;
  logic             main_ld, main_from_skid, skid_ld;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Occupancy register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and payload load selects; flush overrides every handshake.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Payload registers; they only move on a load select, reset, or clearing flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      if (CLR_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (main_ld) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (skid_ld) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_SKID_PERF_EN
  // Downstream back-pressure: holding a live entry that is not taken.
  pipe_sat_cnt #(.W(PERF_CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

  // Upstream starvation: downstream ready but nothing to offer.
  pipe_sat_cnt #(.W(PERF_CNT_W)) u_bubble_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (~out_valid & out_ready),
    .cnt (bubble_cnt)
  );
`endif

endmodule
